// File: rtl/wgt_loader_pkg.sv
// Shared definitions for the weight loader: kernel mode encodings, FSM state
// encodings and the mode -> (kernel rows, bytes per row) geometry lookup.
package wgt_loader_pkg;

    localparam logic [1:0] MODE_2X3X3 = 2'b00;
    localparam logic [1:0] MODE_4X4   = 2'b01;
    localparam logic [1:0] MODE_5X5   = 2'b10;
    localparam logic [1:0] MODE_6X6   = 2'b11;

    // Lane / row counters never exceed 6, so 3 bits cover every mode.
    localparam int LANE_W = 3;

    typedef logic [1:0] state_t;
    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_LOAD  = 2'd1;
    localparam state_t S_WRITE = 2'd2;
    localparam state_t S_DONE  = 2'd3;

    typedef struct packed {
        logic [LANE_W-1:0] k;   // kernel rows written per slot
        logic [LANE_W-1:0] n;   // bytes packed into each row
    } geom_t;

    function automatic geom_t mode_geom(input logic [1:0] mode);
        geom_t g;
        case (mode)
            MODE_2X3X3: begin g.k = 3'd3; g.n = 3'd6; end
            MODE_4X4:   begin g.k = 3'd4; g.n = 3'd4; end
            MODE_5X5:   begin g.k = 3'd5; g.n = 3'd5; end
            MODE_6X6:   begin g.k = 3'd6; g.n = 3'd6; end
            default:    begin g.k = 3'd6; g.n = 3'd6; end
        endcase
        return g;
    endfunction

endpackage

// File: rtl/wgt_loader_row_packer.sv
// Byte-to-row packer: collects accepted bytes into ascending lanes and offers
// the row as it will look once the byte being pushed this cycle is included,
// so the loader can register a complete row on the last byte's handshake.
module wgt_row_packer
    import wgt_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int COLUMN_NUM = 6
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_clr,
    input  logic                             i_push,
    input  logic [DATA_WIDTH-1:0]            i_data,
    input  logic [LANE_W-1:0]                i_n,
    output logic                             o_last,
    output logic [COLUMN_NUM*DATA_WIDTH-1:0] o_row_next
);

    logic [LANE_W-1:0]                       lane_q;
    logic [COLUMN_NUM-1:0][DATA_WIDTH-1:0]   lanes_q;
    logic [COLUMN_NUM-1:0][DATA_WIDTH-1:0]   lanes_d;

    // Merge the incoming byte into its lane; untouched lanes keep their value.
    always_comb begin
        lanes_d = lanes_q;
        for (int j = 0; j < COLUMN_NUM; j++) begin
            if (i_push && (lane_q == LANE_W'(j))) begin
                lanes_d[j] = i_data;
            end else begin
                lanes_d[j] = lanes_q[j];
            end
        end
    end

    assign o_row_next = lanes_d;
    assign o_last     = i_push && (lane_q == (i_n - 3'd1));

    // Lane storage: cleared on reset or after a row write, filled per handshake.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            lane_q  <= '0;
            lanes_q <= '0;
        end else if (i_push) begin
            lane_q  <= lane_q + 3'd1;
            lanes_q <= lanes_d;
        end else begin
            lane_q  <= lane_q;
            lanes_q <= lanes_q;
        end
    end

endmodule

// File: rtl/wgt_loader.sv
// Weight loader: accepts a byte stream, packs it into PE rows according to the
// kernel mode and writes K rows per slot into the per-row weight memories.
// Every output is a register loaded from the FSM's next-state view, so a
// row write is visible in the cycle right after its last byte is accepted.
module wgt_loader
    import wgt_loader_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int ROW_NUM         = 6,
    parameter int COLUMN_NUM      = 6,
    parameter int WMEM_ADDR_WIDTH = 7,
    parameter int ROW_DATA_WIDTH  = DATA_WIDTH * COLUMN_NUM
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_start,
    input  logic [1:0]                 i_mode,
    input  logic [WMEM_ADDR_WIDTH-1:0] i_base_addr,
    input  logic [WMEM_ADDR_WIDTH-1:0] i_num_slots,
    input  logic [DATA_WIDTH-1:0]      i_data,
    input  logic                       i_valid,
    output logic                       o_ready,
    output logic [COLUMN_NUM-1:0]      o_wmem_wr_en,
    output logic [WMEM_ADDR_WIDTH-1:0] o_wmem_wr_addr,
    output logic [ROW_DATA_WIDTH-1:0]  o_wmem_wr_data,
    output logic                       o_busy,
    output logic                       o_done
);

    localparam int ROW_W = $clog2(ROW_NUM);

    state_t                     state_q, state_d;
    logic [LANE_W-1:0]          k_q, k_d;
    logic [LANE_W-1:0]          n_q, n_d;
    logic [ROW_W-1:0]           row_q, row_d;
    logic [WMEM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WMEM_ADDR_WIDTH-1:0] slots_q, slots_d;

    logic                       ready_q;
    logic [COLUMN_NUM-1:0]      wr_en_q, wr_en_d;
    logic [WMEM_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [ROW_DATA_WIDTH-1:0]  wr_data_q, wr_data_d;
    logic                       busy_q;
    logic                       done_q;

    geom_t                      geom_s;
    logic                       push_s;
    logic                       clr_s;
    logic                       last_s;
    logic [ROW_DATA_WIDTH-1:0]  row_next_s;
    logic [COLUMN_NUM-1:0]      one_s;

    assign geom_s = mode_geom(i_mode);
    assign push_s = i_valid && ready_q;
    assign clr_s  = (state_q == S_WRITE);
    assign one_s  = COLUMN_NUM'(1'b1);

    wgt_row_packer #(
        .DATA_WIDTH (DATA_WIDTH),
        .COLUMN_NUM (COLUMN_NUM)
    ) u_packer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clr      (clr_s),
        .i_push     (push_s),
        .i_data     (i_data),
        .i_n        (n_q),
        .o_last     (last_s),
        .o_row_next (row_next_s)
    );

    // FSM next state: slot/row sequencing and parameter latching at start.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        n_d     = n_q;
        row_d   = row_q;
        addr_d  = addr_q;
        slots_d = slots_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    k_d     = geom_s.k;
                    n_d     = geom_s.n;
                    addr_d  = i_base_addr;
                    slots_d = i_num_slots;
                    row_d   = '0;
                    if (i_num_slots == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_LOAD;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if (last_s) begin
                    state_d = S_WRITE;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_WRITE: begin
                if (row_q == ROW_W'(k_q - 3'd1)) begin
                    if (slots_q == WMEM_ADDR_WIDTH'(1'b1)) begin
                        state_d = S_DONE;
                    end else begin
                        row_d   = '0;
                        addr_d  = addr_q + WMEM_ADDR_WIDTH'(1'b1);
                        slots_d = slots_q - WMEM_ADDR_WIDTH'(1'b1);
                        state_d = S_LOAD;
                    end
                end else begin
                    row_d   = row_q + ROW_W'(1'b1);
                    state_d = S_LOAD;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output next values: the write port only changes when entering WRITE.
    always_comb begin
        wr_en_d   = '0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (state_d == S_WRITE) begin
            wr_en_d   = one_s << row_d;
            wr_addr_d = addr_q;
            wr_data_d = row_next_s;
        end else begin
            wr_en_d   = '0;
        end
    end

    // State and output registers; reset abandons any load in progress.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            n_q       <= '0;
            row_q     <= '0;
            addr_q    <= '0;
            slots_q   <= '0;
            ready_q   <= 1'b0;
            wr_en_q   <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            n_q       <= n_d;
            row_q     <= row_d;
            addr_q    <= addr_d;
            slots_q   <= slots_d;
            ready_q   <= (state_d == S_LOAD);
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= (state_d != S_IDLE);
            done_q    <= (state_d == S_DONE);
        end
    end

    assign o_ready        = ready_q;
    assign o_wmem_wr_en   = wr_en_q;
    assign o_wmem_wr_addr = wr_addr_q;
    assign o_wmem_wr_data = wr_data_q;
    assign o_busy         = busy_q;
    assign o_done         = done_q;

endmodule

// File: tb/tb_wgt_loader.sv
// Directed bench for wgt_loader: a table of load scenarios with hand-computed
// summary values, a geometry model for every individual write, plus
// hand-written sequences for reset mid-row, empty loads and start priority.
module tb_wgt_loader;

    logic        clk = 1'b0;
    logic        i_rst, i_start, i_valid;
    logic [1:0]  i_mode;
    logic [6:0]  i_base_addr, i_num_slots;
    logic [7:0]  i_data;
    logic        o_ready, o_busy, o_done;
    logic [5:0]  o_wmem_wr_en;
    logic [6:0]  o_wmem_wr_addr;
    logic [47:0] o_wmem_wr_data;

    wgt_loader dut (
        .i_clk          (clk),
        .i_rst          (i_rst),
        .i_start        (i_start),
        .i_mode         (i_mode),
        .i_base_addr    (i_base_addr),
        .i_num_slots    (i_num_slots),
        .i_data         (i_data),
        .i_valid        (i_valid),
        .o_ready        (o_ready),
        .o_wmem_wr_en   (o_wmem_wr_en),
        .o_wmem_wr_addr (o_wmem_wr_addr),
        .o_wmem_wr_data (o_wmem_wr_data),
        .o_busy         (o_busy),
        .o_done         (o_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]  mode;
        logic [6:0]  base;
        logic [6:0]  slots;
        int          pat;       // 0: b0+i, 1: A0..A2,B0..B2 (+4 per row)
        logic [7:0]  b0;
        bit          stall;     // random i_valid gaps
        bit          restart;   // stray start pulse mid-load
        int          exp_writes;
        logic [47:0] exp_row0;
        logic [6:0]  exp_last_addr;
        logic [47:0] exp_last_data;
    } vec_t;

    int n_checks = 0;
    int n_err    = 0;

    logic [5:0]  w_en[$];
    logic [6:0]  w_addr[$];
    logic [47:0] w_data[$];
    int          w_cyc[$];
    int          d_cyc[$];
    int          acc[$];
    logic [7:0]  bytes[$];
    int          bad_ready = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write/done monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (o_wmem_wr_en != 6'd0) begin
            w_en.push_back(o_wmem_wr_en);
            w_addr.push_back(o_wmem_wr_addr);
            w_data.push_back(o_wmem_wr_data);
            w_cyc.push_back(cyc);
            if (o_ready) bad_ready = bad_ready + 1;
        end
        if (o_done) d_cyc.push_back(cyc);
    end

    function automatic int geo_k(input logic [1:0] m);
        case (m)
            2'b00: return 3;
            2'b01: return 4;
            2'b10: return 5;
            default: return 6;
        endcase
    endfunction

    function automatic int geo_n(input logic [1:0] m);
        case (m)
            2'b00: return 6;
            2'b01: return 4;
            2'b10: return 5;
            default: return 6;
        endcase
    endfunction

    task automatic clear_logs();
        w_en.delete(); w_addr.delete(); w_data.delete(); w_cyc.delete();
        d_cyc.delete(); acc.delete(); bytes.delete();
        bad_ready = 0;
    endtask

    task automatic pulse_start(input logic [1:0] m, input logic [6:0] b, input logic [6:0] s);
        @(negedge clk);
        i_start = 1'b1; i_mode = m; i_base_addr = b; i_num_slots = s;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    // Feed bytes[0..total-1]; optional stalls and a stray start at byte 2.
    task automatic stream(input int total, input bit stall, input bit restart, input string tag);
        int  idx = 0;
        int  guard = 0;
        bit  rs = 1'b0;
        while (idx < total && guard < 3000) begin
            if (guard != 0) @(negedge clk);
            guard++;
            if (restart && idx == 2 && !rs) begin
                i_start = 1'b1; i_mode = 2'b00; i_base_addr = 7'h55; i_num_slots = 7'd3;
                rs = 1'b1;
            end else begin
                i_start = 1'b0;
            end
            if (stall && $urandom_range(0, 1) == 0) begin
                i_valid = 1'b0;
            end else begin
                i_valid = 1'b1;
                i_data  = bytes[idx];
            end
            if (i_valid && o_ready) begin
                acc.push_back(cyc);
                idx++;
            end
        end
        check({tag, " stream complete"}, 64'(idx), 64'(total));
        @(negedge clk);
        i_valid = 1'b0;
        i_start = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int k = geo_k(v.mode);
        int n = geo_n(v.mode);
        int total = k * n * int'(v.slots);
        int guard = 0;
        int nw;
        clear_logs();
        for (int i = 0; i < total; i++) begin
            if (v.pat == 1) begin
                int r = i / 6;
                int j = i % 6;
                bytes.push_back(j < 3 ? 8'(8'hA0 + j + r * 4) : 8'(8'hB0 + (j - 3) + r * 4));
            end else begin
                bytes.push_back(8'(int'(v.b0) + i));
            end
        end
        pulse_start(v.mode, v.base, v.slots);
        check({tag, " busy after start"}, 64'(o_busy), 64'd1);
        check({tag, " ready after start"}, 64'(o_ready), 64'd1);
        stream(total, v.stall, v.restart, tag);
        while (d_cyc.size() == 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        repeat (3) @(negedge clk);
        check({tag, " busy after done"}, 64'(o_busy), 64'd0);
        nw = w_en.size();
        check({tag, " write count"}, 64'(nw), 64'(v.exp_writes));
        check({tag, " done pulses"}, 64'(d_cyc.size()), 64'd1);
        check({tag, " ready low in write"}, 64'(bad_ready), 64'd0);
        if (nw > 0) begin
            check({tag, " row0 data"}, 64'(w_data[0]), 64'(v.exp_row0));
            check({tag, " last addr"}, 64'(w_addr[nw-1]), 64'(v.exp_last_addr));
            check({tag, " last data"}, 64'(w_data[nw-1]), 64'(v.exp_last_data));
            if (d_cyc.size() > 0)
                check({tag, " done timing"}, 64'(d_cyc[0]), 64'(w_cyc[nw-1] + 1));
        end
        for (int w = 0; w < nw && w < v.exp_writes; w++) begin
            logic [47:0] ed = '0;
            logic [6:0]  ea = 7'(int'(v.base) + w / k);
            logic [5:0]  ee = 6'(1 << (w % k));
            for (int j = 0; j < n; j++) ed[j*8 +: 8] = bytes[w*n + j];
            check($sformatf("%s w%0d en", tag, w), 64'(w_en[w]), 64'(ee));
            check($sformatf("%s w%0d addr", tag, w), 64'(w_addr[w]), 64'(ea));
            check($sformatf("%s w%0d data", tag, w), 64'(w_data[w]), 64'(ed));
            if ((w + 1) * n - 1 < acc.size())
                check($sformatf("%s w%0d cycle", tag, w), 64'(w_cyc[w]), 64'(acc[(w+1)*n-1] + 1));
        end
    endtask

    vec_t tbl[5];
    vec_t rv;
    int   sc;

    initial begin
        tbl[0] = '{2'b11, 7'h10, 7'd1, 0, 8'h01, 1'b0, 1'b0, 6,
                   48'h060504030201, 7'h10, 48'h24232221201F};
        tbl[1] = '{2'b01, 7'h7F, 7'd2, 0, 8'h01, 1'b0, 1'b1, 8,
                   48'h000004030201, 7'h00, 48'h0000201F1E1D};
        tbl[2] = '{2'b00, 7'h05, 7'd1, 1, 8'h00, 1'b0, 1'b0, 3,
                   48'hB2B1B0A2A1A0, 7'h05, 48'hBAB9B8AAA9A8};
        tbl[3] = '{2'b10, 7'h20, 7'd2, 0, 8'h40, 1'b1, 1'b0, 10,
                   48'h004443424140, 7'h21, 48'h0071706F6E6D};
        tbl[4] = '{2'b10, 7'h20, 7'd2, 0, 8'h40, 1'b0, 1'b0, 10,
                   48'h004443424140, 7'h21, 48'h0071706F6E6D};

        i_rst = 1'b1; i_start = 1'b0; i_valid = 1'b0; i_mode = 2'b00;
        i_base_addr = 7'h00; i_num_slots = 7'h00; i_data = 8'h00;
        repeat (2) @(negedge clk);
        check("reset outputs", {o_ready, o_wmem_wr_en, o_wmem_wr_addr, o_wmem_wr_data, o_busy, o_done}, 64'd0);
        i_rst = 1'b0;

        for (int t = 0; t < 5; t++) run_vec(tbl[t], $sformatf("vec%0d", t));

        // Empty load: done one cycle after the start is sampled, no writes.
        clear_logs();
        @(negedge clk);
        i_start = 1'b1; i_mode = 2'b11; i_base_addr = 7'h40; i_num_slots = 7'd0;
        sc = cyc;
        @(negedge clk);
        i_start = 1'b0;
        check("empty done", 64'(o_done), 64'd1);
        check("empty ready", 64'(o_ready), 64'd0);
        @(negedge clk);
        check("empty done single", 64'(o_done), 64'd0);
        check("empty busy clear", 64'(o_busy), 64'd0);
        check("empty done cycle", 64'(d_cyc.size() > 0 ? d_cyc[0] : -1), 64'(sc + 1));
        check("empty no writes", 64'(w_en.size()), 64'd0);

        // Reset after the 3rd byte of row 1 in 6x6, with a start in the same cycle.
        clear_logs();
        for (int i = 0; i < 9; i++) bytes.push_back(8'(8'h50 + i));
        pulse_start(2'b11, 7'h08, 7'd1);
        stream(9, 1'b0, 1'b0, "rst");
        i_rst = 1'b1; i_start = 1'b1; i_num_slots = 7'd2;
        @(negedge clk);
        i_rst = 1'b0; i_start = 1'b0;
        check("rst outputs", {o_ready, o_wmem_wr_en, o_wmem_wr_addr, o_wmem_wr_data, o_busy, o_done}, 64'd0);
        check("rst writes before", 64'(w_en.size()), 64'd1);
        repeat (3) @(negedge clk);
        check("rst stays idle", 64'({o_busy, o_ready}), 64'd0);
        check("rst no partial write", 64'(w_en.size()), 64'd1);
        rv = '{2'b11, 7'h30, 7'd1, 0, 8'h80, 1'b0, 1'b0, 6,
               48'h858483828180, 7'h30, 48'hA3A2A1A09F9E};
        run_vec(rv, "post_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
